// File: rtl/gyro_bias_cal.sv
// gyro_bias_cal: removes the static zero-rate bias from a raw 3-axis gyro stream.
// A cal_start_in pulse averages 2^LOG2_SAMPLES valid samples per axis into a
// per-axis bias (floor of the mean). Every valid sample is output as
// saturate(sample - bias) one cycle later. Before the first calibration the bias
// is zero, so the data passes straight through.
// Optional build macro: GYRO_CAL_DEADBAND_EN forces corrected values with
// magnitude <= DEADBAND to zero.
module gyro_bias_cal #(
  parameter int LOG2_SAMPLES = 10,
  parameter int DEADBAND     = 4
) (
  input  logic        clk_100mhz,
  input  logic        reset_n,
  input  logic [15:0] gx_in,
  input  logic [15:0] gy_in,
  input  logic [15:0] gz_in,
  input  logic        valid_in,
  input  logic        cal_start_in,
  output logic [15:0] gx_out,
  output logic [15:0] gy_out,
  output logic [15:0] gz_out,
  output logic        valid_out,
  output logic        cal_busy_out,
  output logic        cal_done_out
);

  localparam int ACC_W = 16 + LOG2_SAMPLES;

`ifdef GYRO_CAL_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  localparam logic signed [16:0] DB_POS = 17'(DEADBAND);
  localparam logic signed [16:0] DB_NEG = -DB_POS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_CAL
  } state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc_x, r_acc_y, r_acc_z;
  logic [LOG2_SAMPLES-1:0]  r_cnt;
  logic signed [15:0]       r_bias_x, r_bias_y, r_bias_z;
  logic signed [15:0]       r_gx_out, r_gy_out, r_gz_out;
  logic                     r_valid_out;
  logic                     r_cal_busy;
  logic                     r_cal_done;

  logic signed [ACC_W-1:0]  w_sum_x, w_sum_y, w_sum_z;

  // Running sum including the sample presented this cycle; the top 16 bits are
  // the floor-divided mean once the final sample is in.
  assign w_sum_x = r_acc_x + {{LOG2_SAMPLES{gx_in[15]}}, gx_in};
  assign w_sum_y = r_acc_y + {{LOG2_SAMPLES{gy_in[15]}}, gy_in};
  assign w_sum_z = r_acc_z + {{LOG2_SAMPLES{gz_in[15]}}, gz_in};

  // sample - bias in 17 bits, clamped to 16-bit signed range, then optional deadband.
  function automatic logic signed [15:0] f_correct(input logic signed [15:0] s,
                                                   input logic signed [15:0] b);
    logic signed [16:0] d;
    logic signed [15:0] q;
    d = {s[15], s} - {b[15], b};
    if (d > 17'sd32767)       q = 16'sh7fff;
    else if (d < -17'sd32768) q = 16'sh8000;
    else                      q = d[15:0];
    if (DB_EN && ($signed({q[15], q}) >= DB_NEG) && ($signed({q[15], q}) <= DB_POS))
      q = '0;
    return q;
  endfunction

  // Calibration control: accumulate, restart on cal_start_in, latch all three biases together.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_acc_z    <= '0;
      r_cnt      <= '0;
      r_bias_x   <= '0;
      r_bias_y   <= '0;
      r_bias_z   <= '0;
      r_cal_busy <= 1'b0;
      r_cal_done <= 1'b0;
    end else if (cal_start_in) begin
      // A start pulse always wins; any sample this cycle is not accumulated.
      r_state    <= S_ACCUM;
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_acc_z    <= '0;
      r_cnt      <= '0;
      r_cal_busy <= 1'b1;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (valid_in) begin
            r_acc_x <= w_sum_x;
            r_acc_y <= w_sum_y;
            r_acc_z <= w_sum_z;
            r_cnt   <= r_cnt + 1'b1;
            if (&r_cnt) begin
              r_bias_x   <= w_sum_x[ACC_W-1:LOG2_SAMPLES];
              r_bias_y   <= w_sum_y[ACC_W-1:LOG2_SAMPLES];
              r_bias_z   <= w_sum_z[ACC_W-1:LOG2_SAMPLES];
              r_state    <= S_CAL;
              r_cal_busy <= 1'b0;
              r_cal_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output path: correct each valid sample with the bias held at that moment.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_out <= 1'b0;
      r_gx_out    <= '0;
      r_gy_out    <= '0;
      r_gz_out    <= '0;
    end else begin
      r_valid_out <= valid_in;
      if (valid_in) begin
        r_gx_out <= f_correct(gx_in, r_bias_x);
        r_gy_out <= f_correct(gy_in, r_bias_y);
        r_gz_out <= f_correct(gz_in, r_bias_z);
      end
    end
  end

  assign gx_out       = r_gx_out;
  assign gy_out       = r_gy_out;
  assign gz_out       = r_gz_out;
  assign valid_out    = r_valid_out;
  assign cal_busy_out = r_cal_busy;
  assign cal_done_out = r_cal_done;

endmodule

// File: doc/gyro_bias_cal.md
# gyro_bias_cal

Removes static zero-rate bias from the raw MPU-6050 gyro stream. It sits between the `mpu_rg` I2C reader and the `process_gyro_simple` integrator. On request it averages 2^LOG2_SAMPLES valid samples per axis, latches the per-axis bias, and then emits bias-corrected, saturated rate samples. Until the first calibration completes it passes raw data through with zero bias.

## Interface

**Parameters**
- `LOG2_SAMPLES`, default 10: log2 of the number of samples averaged (1024). Legal range is 1..16.
- `DEADBAND`, default 4: magnitude in LSB at or below which corrected output is forced to 0. Used only with `GYRO_CAL_DEADBAND_EN`.

**Ports**
- `clk_100mhz` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `gx_in`, `gy_in`, `gz_in` in 16 each: raw gyro rates, signed two's complement.
- `valid_in` in 1: one-cycle strobe; the three axes are sampled on this cycle.
- `cal_start_in` in 1: one-cycle pulse that starts, or restarts, calibration.
- `gx_out`, `gy_out`, `gz_out` out 16 each: corrected rates, signed.
- `valid_out` out 1: one-cycle strobe qualifying the `*_out` data.
- `cal_busy_out` out 1: high while accumulating.
- `cal_done_out` out 1: high once at least one calibration has completed; sticky until reset.

## Operation

**State machine: IDLE, ACCUM, CAL.**
- IDLE: bias registers are 0. `cal_start_in` moves to ACCUM.
- ACCUM:
  - Accumulators and sample counter are cleared on entry.
  - Each `valid_in` adds the sign-extended sample to the per-axis accumulator and increments the counter.
  - When the counter reaches 2^LOG2_SAMPLES − 1 and `valid_in` is high, that last sample is included.
  - Bias is then set to the accumulated sum arithmetic-shifted right by LOG2_SAMPLES, rounding toward −inf, and the state moves to CAL.
- CAL: bias held. `cal_start_in` moves to ACCUM.

**Widths and arithmetic**
- Accumulator: 16+LOG2_SAMPLES bits, signed.
- Counter: LOG2_SAMPLES bits.
- Bias: 16 bits, signed.
- Correction is sample − bias, computed in 17 bits and saturated to [−32768, 32767].

**Boundary conditions**
- `cal_start_in` during ACCUM: accumulators and counter clear and counting restarts. The old bias is kept until the new run completes.
- Correction continues in every state using the currently held bias. In ACCUM the output therefore uses the previous bias, or 0 if none exists.
- `valid_in` and `cal_start_in` in the same cycle in IDLE or CAL: the sample is output corrected with the old bias and is not accumulated.
- `valid_in` and `cal_start_in` in the same cycle in ACCUM: the restart wins and the sample is discarded from the sum.
- Final-sample cycle: the output for that sample uses the old bias. The new bias applies from the next `valid_in`.
- Reset mid-ACCUM: returns to IDLE with bias = 0 and `cal_done_out` = 0.

## Timing

- All outputs are registered.
- Reset values: `gx_out`, `gy_out`, `gz_out` = 0; `valid_out` = 0; `cal_busy_out` = 0; `cal_done_out` = 0.
- Latency: `valid_out` is asserted exactly 1 cycle after `valid_in`. Data holds until the next `valid_out`.
- Back-to-back `valid_in` on every cycle is supported with no stalls and no backpressure.
- `cal_busy_out` rises the cycle after `cal_start_in` and falls the cycle after the final sample is accepted.
- `cal_done_out` rises in the same cycle that `cal_busy_out` falls.
- The bias update is atomic across all three axes; no mixed-axis bias is ever visible.

## Configuration

- `GYRO_CAL_DEADBAND_EN` defined: after saturation, any axis with |corrected| ≤ DEADBAND outputs 0, applied per axis.
- `GYRO_CAL_DEADBAND_EN` undefined: the saturated value is output unchanged and `DEADBAND` is ignored.
- Latency is identical in both builds.

## Test plan

All scenarios use `LOG2_SAMPLES` = 2 and deadband disabled unless stated.

1. **Reset pass-through.** Release reset, then `valid_in` with gx = 100, gy = −5, gz = 0 → next cycle `valid_out` = 1, outputs 100, −5, 0; `cal_done_out` = 0.
2. **Calibration.** `cal_start_in`, then 4 samples of gx = 10, 12, 14, 16 (gy = gz = −3) → `cal_busy_out` for the run, then `cal_done_out` = 1. Next sample gx = 20, gy = 0 gives gx_out = 7 and gy_out = 3.
3. **Negative rounding.** Calibrate on gx = −1, −1, −1, −2 → bias = −2 (floor of −5/4). A subsequent gx = 0 outputs 2.
4. **Saturation.**
   - Bias gx = −100, input 32767 → 32767.
   - Bias gx = 100, input −32768 → −32768.
5. **Restart and reset mid-run.**
   - `cal_start_in` after 2 of 4 samples → 4 further samples are required before `cal_done_out`; the earlier 2 are excluded from the bias.
   - Separately, `reset_n` low during ACCUM → all outputs return to 0 and pass-through is restored.
6. **Deadband build.** With `GYRO_CAL_DEADBAND_EN`, `DEADBAND` = 4, zero bias → inputs 4, −4, 5 give outputs 0, 0, 5.
